// File: rtl/cpu_run_monitor_if.sv
// Purpose: self-check RAM read bus shared by the data RAM and the expected-image RAM.
// Ports:
//   chk_r_addr  byte address presented to both RAM read ports
//   chk_r_enb   read enable for both RAMs
//   chk_r_dat   data RAM read data (1-cycle latency)
//   exp_r_dat   expected RAM read data (1-cycle latency)
// master = cpu_run_monitor, slave = RAM side.
interface cpu_run_monitor_if #(
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned DATA_WIDTH = 32
) ();
    logic [ADDR_WIDTH-1:0] chk_r_addr;
    logic                  chk_r_enb;
    logic [DATA_WIDTH-1:0] chk_r_dat;
    logic [DATA_WIDTH-1:0] exp_r_dat;

    modport master (
        output chk_r_addr,
        output chk_r_enb,
        input  chk_r_dat,
        input  exp_r_dat
    );

    modport slave (
        input  chk_r_addr,
        input  chk_r_enb,
        output chk_r_dat,
        output exp_r_dat
    );
endinterface

// File: rtl/cpu_run_monitor.sv
// Purpose: run control and on-chip self-check for the RV32I core. Holds the core
// stalled until start, releases it, detects halt (PC stops advancing) or cycle
// timeout, then compares a window of data RAM against an expected-image RAM.
// Ports:
//   clk, rst        clock (rising edge), asynchronous active-low reset
//   start           one-cycle pulse starting a run (accepted in IDLE/DONE only)
//   pc              core program counter
//   pc_stall        1 = core held
//   chk             RAM read bus (address/enable out, both read data in)
//   busy, done      in RUN/SCAN, in DONE
//   pass            no mismatches and no timeout (valid with done)
//   timeout         run hit MAX_CYCLES
//   err_count       saturating mismatch count
//   first_err_addr  byte address of the first mismatch
//   cycle_count     saturating count of run cycles
module cpu_run_monitor #(
    parameter int unsigned ADDR_WIDTH  = 12,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned MAX_CYCLES  = 1000,
    parameter int unsigned HALT_STABLE = 1,
    parameter int unsigned CHECK_BASE  = 0,
    parameter int unsigned CHECK_WORDS = 1024,
    parameter int unsigned CNT_WIDTH   = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] pc,
    output logic                  pc_stall,
    cpu_run_monitor_if.master     chk,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic                  timeout,
    output logic [CNT_WIDTH-1:0]  err_count,
    output logic [ADDR_WIDTH-1:0] first_err_addr,
    output logic [CNT_WIDTH-1:0]  cycle_count
);

    localparam int unsigned STB_W = $clog2(HALT_STABLE + 1);
    localparam int unsigned IDX_W = (CHECK_WORDS > 1) ? $clog2(CHECK_WORDS) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        SCAN = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] pc_q, pc_d;
    logic                  pc_valid_q, pc_valid_d;
    logic [STB_W-1:0]      stable_q, stable_d;
    logic [CNT_WIDTH-1:0]  cycle_q, cycle_d;
    logic                  timeout_q, timeout_d;
    logic [CNT_WIDTH-1:0]  err_q, err_d;
    logic [ADDR_WIDTH-1:0] first_err_q, first_err_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [ADDR_WIDTH-1:0] chk_r_addr_q, chk_r_addr_d;
    logic                  chk_r_enb_q, chk_r_enb_d;
    logic                  cmp_valid_q, cmp_valid_d;
    logic                  cmp_last_q, cmp_last_d;
    logic [ADDR_WIDTH-1:0] cmp_addr_q, cmp_addr_d;
    logic                  pc_stall_q, pc_stall_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  pass_q, pass_d;
    logic                  mismatch_c;
    logic                  issue_last_c;

    // RAM data arriving this cycle belongs to the address issued last cycle
    assign mismatch_c   = cmp_valid_q && (chk.chk_r_dat != chk.exp_r_dat);
    assign issue_last_c = (idx_q == IDX_W'(CHECK_WORDS - 1));

    // Next-state and next-output logic
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        pc_valid_d   = pc_valid_q;
        stable_d     = stable_q;
        cycle_d      = cycle_q;
        timeout_d    = timeout_q;
        err_d        = err_q;
        first_err_d  = first_err_q;
        idx_d        = idx_q;
        chk_r_addr_d = chk_r_addr_q;
        chk_r_enb_d  = 1'b0;
        cmp_valid_d  = 1'b0;
        cmp_last_d   = 1'b0;
        cmp_addr_d   = cmp_addr_q;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d     = RUN;
                    pc_valid_d  = 1'b0;
                    stable_d    = '0;
                    cycle_d     = '0;
                    timeout_d   = 1'b0;
                    err_d       = '0;
                    first_err_d = '0;
                end
            end

            RUN: begin
                cycle_d    = (cycle_q == '1) ? cycle_q : cycle_q + CNT_WIDTH'(1);
                pc_d       = pc;
                pc_valid_d = 1'b1;
                if (pc_valid_q && (pc == pc_q)) begin
                    stable_d = stable_q + STB_W'(1);
                end else begin
                    stable_d = '0;
                end
                // Halt has priority over a timeout qualifying in the same cycle
                if (stable_d == STB_W'(HALT_STABLE)) begin
                    state_d = SCAN;
                end else if (32'(cycle_d) >= MAX_CYCLES) begin
                    state_d   = SCAN;
                    timeout_d = 1'b1;
                end
                if (state_d == SCAN) begin
                    idx_d        = '0;
                    chk_r_addr_d = ADDR_WIDTH'(CHECK_BASE);
                    chk_r_enb_d  = 1'b1;
                end
            end

            SCAN: begin
                // Issue stage
                cmp_valid_d = chk_r_enb_q;
                cmp_last_d  = chk_r_enb_q && issue_last_c;
                cmp_addr_d  = chk_r_addr_q;
                if (chk_r_enb_q && !issue_last_c) begin
                    idx_d        = idx_q + IDX_W'(1);
                    chk_r_addr_d = chk_r_addr_q + ADDR_WIDTH'(4);
                    chk_r_enb_d  = 1'b1;
                end
                // Compare stage; err_q == 0 marks the first mismatch
                if (mismatch_c) begin
                    err_d = (err_q == '1) ? err_q : err_q + CNT_WIDTH'(1);
                    if (err_q == '0) begin
                        first_err_d = cmp_addr_q;
                    end
                end
                if (cmp_valid_q && cmp_last_q) begin
                    state_d = DONE;
                end
            end

            default: state_d = IDLE;
        endcase

        pc_stall_d = (state_d != RUN);
        busy_d     = (state_d == RUN) || (state_d == SCAN);
        done_d     = (state_d == DONE);
        pass_d     = (state_d == DONE) && (err_d == '0) && !timeout_d;
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            pc_q         <= '0;
            pc_valid_q   <= 1'b0;
            stable_q     <= '0;
            cycle_q      <= '0;
            timeout_q    <= 1'b0;
            err_q        <= '0;
            first_err_q  <= '0;
            idx_q        <= '0;
            chk_r_addr_q <= '0;
            chk_r_enb_q  <= 1'b0;
            cmp_valid_q  <= 1'b0;
            cmp_last_q   <= 1'b0;
            cmp_addr_q   <= '0;
            pc_stall_q   <= 1'b1;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            pc_valid_q   <= pc_valid_d;
            stable_q     <= stable_d;
            cycle_q      <= cycle_d;
            timeout_q    <= timeout_d;
            err_q        <= err_d;
            first_err_q  <= first_err_d;
            idx_q        <= idx_d;
            chk_r_addr_q <= chk_r_addr_d;
            chk_r_enb_q  <= chk_r_enb_d;
            cmp_valid_q  <= cmp_valid_d;
            cmp_last_q   <= cmp_last_d;
            cmp_addr_q   <= cmp_addr_d;
            pc_stall_q   <= pc_stall_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            pass_q       <= pass_d;
        end
    end

    assign pc_stall       = pc_stall_q;
    assign chk.chk_r_addr = chk_r_addr_q;
    assign chk.chk_r_enb  = chk_r_enb_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign pass           = pass_q;
    assign timeout        = timeout_q;
    assign err_count      = err_q;
    assign first_err_addr = first_err_q;
    assign cycle_count    = cycle_q;

endmodule

// File: tb/tb_cpu_run_monitor.sv
// Bench for cpu_run_monitor. DUT A: HALT_STABLE=3, MAX_CYCLES=50, 32 words from 0x000.
// DUT B: HALT_STABLE=1, CNT_WIDTH=1, 8 words from 0xFF8 (window wraps to 0x014).
module tb_cpu_run_monitor;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_a, start_b;
    logic [31:0] pc_a, pc_b;
    logic        stall_a, busy_a, done_a, pass_a, to_a;
    logic        stall_b, busy_b, done_b, pass_b, to_b;
    logic [15:0] err_a, cyc_a;
    logic [0:0]  err_b, cyc_b;
    logic [11:0] first_a, first_b;

    cpu_run_monitor_if #(.ADDR_WIDTH(12), .DATA_WIDTH(32)) bus_a ();
    cpu_run_monitor_if #(.ADDR_WIDTH(12), .DATA_WIDTH(32)) bus_b ();

    cpu_run_monitor #(
        .ADDR_WIDTH(12), .DATA_WIDTH(32), .MAX_CYCLES(50), .HALT_STABLE(3),
        .CHECK_BASE(0), .CHECK_WORDS(32), .CNT_WIDTH(16)
    ) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .pc(pc_a), .pc_stall(stall_a),
        .chk(bus_a), .busy(busy_a), .done(done_a), .pass(pass_a), .timeout(to_a),
        .err_count(err_a), .first_err_addr(first_a), .cycle_count(cyc_a)
    );

    cpu_run_monitor #(
        .ADDR_WIDTH(12), .DATA_WIDTH(32), .MAX_CYCLES(20), .HALT_STABLE(1),
        .CHECK_BASE(32'hFF8), .CHECK_WORDS(8), .CNT_WIDTH(1)
    ) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .pc(pc_b), .pc_stall(stall_b),
        .chk(bus_b), .busy(busy_b), .done(done_b), .pass(pass_b), .timeout(to_b),
        .err_count(err_b), .first_err_addr(first_b), .cycle_count(cyc_b)
    );

    always #5 clk = ~clk;

    logic [31:0] data_mem [1024];
    logic [31:0] exp_mem  [1024];

    // Synchronous-read RAM models, one-cycle latency
    always @(posedge clk) begin
        if (bus_a.chk_r_enb) begin
            bus_a.chk_r_dat <= data_mem[bus_a.chk_r_addr[11:2]];
            bus_a.exp_r_dat <= exp_mem[bus_a.chk_r_addr[11:2]];
        end
        if (bus_b.chk_r_enb) begin
            bus_b.chk_r_dat <= data_mem[bus_b.chk_r_addr[11:2]];
            bus_b.exp_r_dat <= exp_mem[bus_b.chk_r_addr[11:2]];
        end
    end

    typedef struct {
        int sel;     // 0 = DUT A, 1 = DUT B
        int mode;    // PC program
        int bad0;    // corrupted expected byte address, -1 none
        int bad1;
        int glitch;  // RUN cycle after which start is pulsed, -1 none
        int gscan;   // pulse start during SCAN
        int e_err;
        int e_first;
        int e_pass;
        int e_to;
        int e_cyc;
        int e_run;
        int e_scan;
    } vec_t;

    int nchecks = 0;
    int nerr    = 0;
    int g_stall, g_enb, g_addr, g_busy, g_done, g_pass, g_to, g_err, g_first, g_cyc;
    vec_t vecs [10];

    function automatic vec_t mk(int sel, int mode, int bad0, int bad1, int glitch, int gscan,
                                int e_err, int e_first, int e_pass, int e_to, int e_cyc,
                                int e_run, int e_scan);
        vec_t v;
        v.sel = sel; v.mode = mode; v.bad0 = bad0; v.bad1 = bad1;
        v.glitch = glitch; v.gscan = gscan;
        v.e_err = e_err; v.e_first = e_first; v.e_pass = e_pass; v.e_to = e_to;
        v.e_cyc = e_cyc; v.e_run = e_run; v.e_scan = e_scan;
        return v;
    endfunction

    // PC seen on the n-th RUN cycle
    function automatic logic [31:0] pc_at(int mode, int n);
        case (mode)
            0: return (n < 7) ? 32'(4 * n) : 32'd28;          // 7 instrs then jal x0,0 at 0x1C
            1: return 32'((n % 2) * 4);                       // 0x0/0x4 forever
            2: begin                                          // 0x8 held 3 cycles, then halt at 0x10
                case (n)
                    0: return 32'd0;
                    1: return 32'd4;
                    2, 3, 4: return 32'd8;
                    5: return 32'd12;
                    default: return 32'd16;
                endcase
            end
            default: return (n <= 46) ? 32'((n % 2) * 4) : 32'd0;  // halt lands on cycle 50
        endcase
    endfunction

    task automatic check(input string name, input int got, input int exp);
        nchecks++;
        if (got != exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic read_outs(input int sel);
        if (sel == 0) begin
            g_stall = int'(stall_a); g_enb = int'(bus_a.chk_r_enb); g_addr = int'(bus_a.chk_r_addr);
            g_busy = int'(busy_a); g_done = int'(done_a); g_pass = int'(pass_a); g_to = int'(to_a);
            g_err = int'(err_a); g_first = int'(first_a); g_cyc = int'(cyc_a);
        end else begin
            g_stall = int'(stall_b); g_enb = int'(bus_b.chk_r_enb); g_addr = int'(bus_b.chk_r_addr);
            g_busy = int'(busy_b); g_done = int'(done_b); g_pass = int'(pass_b); g_to = int'(to_b);
            g_err = int'(err_b); g_first = int'(first_b); g_cyc = int'(cyc_b);
        end
    endtask

    task automatic set_start(input int sel, input logic v);
        if (sel == 0) start_a = v; else start_b = v;
    endtask

    task automatic set_pc(input int sel, input logic [31:0] v);
        if (sel == 0) pc_a = v; else pc_b = v;
    endtask

    task automatic check_reset_vals(input int sel, input string tag);
        read_outs(sel);
        check({tag, "_pc_stall"}, g_stall, 1);
        check({tag, "_chk_r_enb"}, g_enb, 0);
        check({tag, "_chk_r_addr"}, g_addr, 0);
        check({tag, "_busy"}, g_busy, 0);
        check({tag, "_done"}, g_done, 0);
        check({tag, "_pass"}, g_pass, 0);
        check({tag, "_timeout"}, g_to, 0);
        check({tag, "_err_count"}, g_err, 0);
        check({tag, "_first_err_addr"}, g_first, 0);
        check({tag, "_cycle_count"}, g_cyc, 0);
    endtask

    task automatic load_mems(input int bad0, input int bad1);
        for (int i = 0; i < 1024; i++) begin
            data_mem[i] = 32'(i);
            exp_mem[i]  = 32'(i);
        end
        if (bad0 >= 0) exp_mem[bad0 >> 2] = exp_mem[bad0 >> 2] ^ 32'hDEAD_0000;
        if (bad1 >= 0) exp_mem[bad1 >> 2] = exp_mem[bad1 >> 2] ^ 32'hDEAD_0000;
    endtask

    // Start a run and drive PCs until the monitor stalls the core; returns RUN cycles
    task automatic do_run(input vec_t v, output int n, output int ok);
        set_pc(v.sel, 32'd0);
        set_start(v.sel, 1'b1);
        @(posedge clk); #1;
        set_start(v.sel, 1'b0);
        read_outs(v.sel);
        check("start_releases_stall", g_stall, 0);
        check("start_sets_busy", g_busy, 1);
        n  = 0;
        ok = 0;
        set_pc(v.sel, pc_at(v.mode, 0));
        for (int k = 0; k < 200; k++) begin
            @(posedge clk); #1;
            n++;
            read_outs(v.sel);
            if (g_stall != 0) begin
                ok = 1;
                break;
            end
            set_start(v.sel, (v.glitch == n) ? 1'b1 : 1'b0);
            set_pc(v.sel, pc_at(v.mode, n));
        end
        set_start(v.sel, 1'b0);
    endtask

    task automatic run_vector(input vec_t v, input int idx);
        int n, ok, m;
        string tag;
        tag = $sformatf("v%0d", idx);
        load_mems(v.bad0, v.bad1);
        do_run(v, n, ok);
        check({tag, "_run_bounded"}, ok, 1);
        check({tag, "_run_cycles"}, n, v.e_run);
        m  = 0;
        ok = 0;
        for (int k = 0; k < 200; k++) begin
            @(posedge clk); #1;
            m++;
            set_start(v.sel, (v.gscan != 0 && m == 3) ? 1'b1 : 1'b0);
            read_outs(v.sel);
            if (g_done != 0) begin
                ok = 1;
                break;
            end
        end
        set_start(v.sel, 1'b0);
        check({tag, "_scan_bounded"}, ok, 1);
        check({tag, "_scan_cycles"}, m, v.e_scan);
        check({tag, "_err_count"}, g_err, v.e_err);
        check({tag, "_first_err_addr"}, g_first, v.e_first);
        check({tag, "_pass"}, g_pass, v.e_pass);
        check({tag, "_timeout"}, g_to, v.e_to);
        check({tag, "_cycle_count"}, g_cyc, v.e_cyc);
        check({tag, "_busy"}, g_busy, 0);
        check({tag, "_pc_stall"}, g_stall, 1);
        check({tag, "_chk_r_enb"}, g_enb, 0);
        @(posedge clk); #1;
        read_outs(v.sel);
        check({tag, "_done_hold"}, g_done, 1);
        check({tag, "_pass_hold"}, g_pass, v.e_pass);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, ok;
        vecs[0] = mk(0, 0,    -1,    -1, -1, 1, 0, 12'h000, 1, 0, 11, 11, 33);
        vecs[1] = mk(0, 0, 'h040,    -1, -1, 0, 1, 12'h040, 0, 0, 11, 11, 33);
        vecs[2] = mk(0, 1,    -1,    -1, 20, 0, 0, 12'h000, 0, 1, 50, 50, 33);
        vecs[3] = mk(0, 2,    -1,    -1, -1, 0, 0, 12'h000, 1, 0, 10, 10, 33);
        vecs[4] = mk(0, 0, 'h004, 'h07C, -1, 0, 2, 12'h004, 0, 0, 11, 11, 33);
        vecs[5] = mk(0, 0, 'h080,    -1, -1, 0, 0, 12'h000, 1, 0, 11, 11, 33);
        vecs[6] = mk(0, 3,    -1,    -1, -1, 0, 0, 12'h000, 1, 0, 50, 50, 33);
        vecs[7] = mk(1, 0, 'h008, 'h00C, -1, 0, 1, 12'h008, 0, 0,  1,  9,  9);
        vecs[8] = mk(1, 0,    -1,    -1, -1, 0, 0, 12'h000, 1, 0,  1,  9,  9);
        vecs[9] = mk(1, 0, 'h000, 'hFF8, -1, 1, 1, 12'hFF8, 0, 0,  1,  9,  9);

        rst     = 1'b0;
        start_a = 1'b0;
        start_b = 1'b0;
        pc_a    = '0;
        pc_b    = '0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_vals(0, "rst_a");
        check_reset_vals(1, "rst_b");
        rst = 1'b1;
        @(posedge clk); #1;
        check_reset_vals(0, "idle_a");

        for (int i = 0; i < 10; i++) begin
            run_vector(vecs[i], i);
        end

        // Reset in the middle of SCAN, after the 0x040 mismatch has been counted
        load_mems('h040, -1);
        do_run(vecs[1], n, ok);
        check("midscan_run_bounded", ok, 1);
        repeat (20) @(posedge clk);
        #1;
        read_outs(0);
        check("midscan_busy_before_reset", g_busy, 1);
        check("midscan_err_before_reset", g_err, 1);
        rst = 1'b0;
        #1;
        check_reset_vals(0, "midscan_rst");
        @(posedge clk); #1;
        check_reset_vals(0, "midscan_rst_held");
        rst = 1'b1;
        @(posedge clk); #1;
        run_vector(vecs[1], 10);

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
        $finish;
    end

endmodule

// File: doc/cpu_run_monitor.md
# cpu_run_monitor

Synthesisable run-control and self-check block for the RV32I core. It holds the core stalled until started, releases `pc_stall`, detects program halt (PC stops advancing) or cycle timeout, then scans a window of data RAM against an expected-image RAM. It reports a pass/fail summary, which lets on-FPGA regression runs reproduce the simulation full-CPU check without a testbench.

## Interface
Parameters:
- `ADDR_WIDTH`, 12: RAM byte-address width.
- `DATA_WIDTH`, 32: word width.
- `MAX_CYCLES`, 1000: run-cycle limit before timeout; must be ≥ 1.
- `HALT_STABLE`, 1: consecutive cycles with unchanged PC that declare halt; must be ≥ 1.
- `CHECK_BASE`, 0: first byte address scanned; word-aligned.
- `CHECK_WORDS`, 1024: number of words scanned; must be ≥ 1.
- `CNT_WIDTH`, 16: width of the counters.

Ports:
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: asynchronous, active-low reset.
- `start`  in  1: single-cycle pulse; begins a run.
- `pc`  in  DATA_WIDTH: core program counter (`pc_out`).
- `pc_stall`  out  1: stall to core; 1 = halted.
- `chk_r_addr`  out  ADDR_WIDTH: byte address to both data RAM and expected RAM read ports.
- `chk_r_enb`  out  1: read enable for both RAMs.
- `chk_r_dat`  in  DATA_WIDTH: data RAM read data; 1-cycle latency.
- `exp_r_dat`  in  DATA_WIDTH: expected RAM read data; 1-cycle latency.
- `busy`  out  1: in RUN or SCAN.
- `done`  out  1: in DONE.
- `pass`  out  1: valid when `done`.
- `timeout`  out  1: run hit MAX_CYCLES.
- `err_count`  out  CNT_WIDTH: mismatching words; saturates at all-ones.
- `first_err_addr`  out  ADDR_WIDTH: byte address of the first mismatch.
- `cycle_count`  out  CNT_WIDTH: run cycles consumed.

## Operation
- States: IDLE, RUN, SCAN, DONE.
- IDLE: `pc_stall`=1. `start` → RUN. On that transition, clear `err_count`, `timeout`, `cycle_count` and `first_err_addr`, and invalidate `pc_q`.
- RUN: `pc_stall`=0.
  - Each cycle, `cycle_count`++ and `pc_q` ← `pc`.
  - On the first RUN cycle, `pc_q` is invalid and no comparison is made.
  - After that, if `pc == pc_q`, the stable counter increments; otherwise it clears.
  - When the stable counter reaches HALT_STABLE → SCAN.
  - Otherwise, when `cycle_count` reaches MAX_CYCLES: set `timeout`=1 → SCAN.
  - If halt and timeout qualify in the same cycle, halt wins and `timeout` stays 0.
- SCAN: `pc_stall`=1.
  - Index i runs 0..CHECK_WORDS-1, one per cycle, with `chk_r_addr` = CHECK_BASE + 4·i (modulo 2^ADDR_WIDTH) and `chk_r_enb`=1.
  - The compare stage is registered one cycle behind and uses the delayed address.
  - On a mismatch: `err_count`++ (saturating). On the first mismatch only, latch `first_err_addr`.
  - After the compare of the last word → DONE.
  - `chk_r_enb`=0 outside the issue cycles.
- DONE: `pass` = (`err_count`==0) && !`timeout`. Outputs hold. `start` → RUN, with the same clearing as from IDLE.
- `start` is ignored in RUN and SCAN.
- `cycle_count` saturates and does not wrap.

## Timing
- Reset values: state IDLE, `pc_stall`=1, `chk_r_enb`=0, `chk_r_addr`=0, `busy`=0, `done`=0, `pass`=0, `timeout`=0, `err_count`=0, `first_err_addr`=0, `cycle_count`=0.
- Reset asserted mid-RUN or mid-SCAN aborts immediately to the reset values; no partial results are retained.
- `start` sampled at edge k → `pc_stall` low from edge k+1.
- Halt detection: `pc_stall` high at the edge after the stable counter reaches HALT_STABLE; a minimum of HALT_STABLE+1 RUN cycles.
- Timeout: exactly MAX_CYCLES RUN cycles with `pc_stall`=0, then `pc_stall`=1.
- SCAN length: CHECK_WORDS issue cycles plus 1 drain cycle; `done` rises the cycle after the final compare.
- All outputs are registered; there is no combinational path from any input to any output.

## Test plan
- Straight-line program ending in `jal x0,0`; expected RAM equals the result image → `done`=1, `pass`=1, `err_count`=0, `timeout`=0, and `cycle_count` equals the instruction count plus HALT_STABLE+1.
- Same program with expected word 0x0000_0010 corrupted at byte address 0x040, CHECK_WORDS=32 → `err_count`=1, `first_err_addr`=0x040, `pass`=0.
- Infinite loop (PC alternating 0x0/0x4), MAX_CYCLES=50 → `pc_stall`=1 after exactly 50 run cycles, `timeout`=1, `pass`=0, scan still completes.
- Mismatches at 0x008 and 0x00C with CNT_WIDTH=1 → `err_count` saturates at 1, `first_err_addr`=0x008.
- Reset pulsed mid-SCAN, then `start` → all outputs return to their reset values; the rerun produces identical results. `start` pulsed during RUN is ignored.
- HALT_STABLE=3 with a program that repeats one PC for 2 cycles before moving on → no premature halt; the real halt is detected after 3 stable cycles.
